// File: rtl/otter_mem_pkg.sv
// Shared types for the data-side memory port arbiter.
//   arb_state_t : arbiter FSM states (IDLE, RD_WAIT)
//   SZ_*        : access size encodings carried on C_SIZE / MEM_SIZE
//   owner_t     : which requester drives the memory port this cycle
package otter_mem_pkg;

    typedef enum logic {
        IDLE,
        RD_WAIT
    } arb_state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CPU,
        OWN_PROG
    } owner_t;

endpackage

// File: rtl/mem2_port_arbiter_starve_ctr.sv
// arb_starve_ctr: clearable up-counter with a compare-to-limit flag.
//   CLK, RESET_N : clock, async active-low reset (count -> 0)
//   inc          : count up by one this cycle
//   clr          : synchronous clear, wins over inc
//   cnt          : current count
//   at_max       : cnt >= MAX
// The caller gates inc with at_max, so the count holds at MAX (saturates).
module arb_starve_ctr #(
    parameter int          W   = 8,
    parameter int unsigned MAX = 8
) (
    input  logic         CLK,
    input  logic         RESET_N,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         at_max
);

    localparam logic [W-1:0] LIM = W'(MAX);

    assign at_max = (cnt >= LIM);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)  cnt <= '0;
        else if (clr)  cnt <= '0;
        else if (inc)  cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/mem2_port_arbiter.sv
// mem2_port_arbiter: shares the byte memory's second (data) port between the
// CPU load/store stage and the serial programmer with a request/grant
// handshake, tracks the read-latency window and raises the CPU stall.
//   CPU side   : C_REQ/C_WE/C_ADDR/C_DIN/C_SIZE/C_SIGN in; C_GNT, C_RVALID,
//                C_DOUT, CPU_STALL out
//   Programmer : P_REQ/P_ADDR/P_DIN in (word writes only); P_GNT out
//   Memory     : MEM_ADDR2/MEM_DIN2/MEM_WRITE2/MEM_READ2/MEM_SIZE/MEM_SIGN out;
//                MEM_DOUT2 in
// Optional build macro MEM2_ARB_PERF_EN adds CONFLICT_CNT and STALL_CNT,
// 16-bit saturating event counters.
module mem2_port_arbiter
    import otter_mem_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 8
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              C_REQ,
    input  logic              C_WE,
    input  logic [ADDR_W-1:0] C_ADDR,
    input  logic [DATA_W-1:0] C_DIN,
    input  logic [1:0]        C_SIZE,
    input  logic              C_SIGN,
    output logic              C_GNT,
    output logic              C_RVALID,
    output logic [DATA_W-1:0] C_DOUT,
    output logic              CPU_STALL,
    input  logic              P_REQ,
    input  logic [ADDR_W-1:0] P_ADDR,
    input  logic [DATA_W-1:0] P_DIN,
    output logic              P_GNT,
    output logic [ADDR_W-1:0] MEM_ADDR2,
    output logic [DATA_W-1:0] MEM_DIN2,
    output logic              MEM_WRITE2,
    output logic              MEM_READ2,
    output logic [1:0]        MEM_SIZE,
    output logic              MEM_SIGN,
    input  logic [DATA_W-1:0] MEM_DOUT2
`ifdef MEM2_ARB_PERF_EN
    ,
    output logic [15:0]       CONFLICT_CNT,
    output logic [15:0]       STALL_CNT
`endif
);

    arb_state_t state, nxt_state;
    logic [2:0] lat_cnt, lat_nxt;
    owner_t     owner;
    logic [7:0] starve;
    logic       starve_full;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state   <= IDLE;
            lat_cnt <= '0;
        end else begin
            state   <= nxt_state;
            lat_cnt <= lat_nxt;
        end
    end

    // Grant only from IDLE. RESET_N gates the decision so no grant or strobe
    // can appear while reset is held, even with requests pending.
    always_comb begin
        owner     = OWN_NONE;
        nxt_state = state;
        lat_nxt   = lat_cnt;
        C_RVALID  = 1'b0;
        case (state)
            IDLE: begin
                if (RESET_N) begin
                    if (P_REQ && (!C_REQ || (starve < 8'(STARVE_MAX)))) begin
                        owner = OWN_PROG;
                    end else if (C_REQ) begin
                        owner = OWN_CPU;
                        if (!C_WE) begin
                            nxt_state = RD_WAIT;
                            lat_nxt   = 3'(RD_LAT);
                        end
                    end
                end
            end
            RD_WAIT: begin
                if (lat_cnt == 3'd1) begin
                    C_RVALID  = 1'b1;
                    nxt_state = IDLE;
                    lat_nxt   = '0;
                end else begin
                    lat_nxt = lat_cnt - 3'd1;
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    assign C_GNT = (owner == OWN_CPU);
    assign P_GNT = (owner == OWN_PROG);

    always_comb begin
        MEM_ADDR2  = '0;
        MEM_DIN2   = '0;
        MEM_WRITE2 = 1'b0;
        MEM_READ2  = 1'b0;
        MEM_SIZE   = SZ_BYTE;
        MEM_SIGN   = 1'b0;
        case (owner)
            OWN_PROG: begin
                MEM_ADDR2  = P_ADDR;
                MEM_DIN2   = P_DIN;
                MEM_WRITE2 = 1'b1;
                MEM_SIZE   = SZ_WORD;
            end
            OWN_CPU: begin
                MEM_ADDR2  = C_ADDR;
                MEM_DIN2   = C_DIN;
                MEM_WRITE2 = C_WE;
                MEM_READ2  = ~C_WE;
                MEM_SIZE   = C_SIZE;
                MEM_SIGN   = C_SIGN;
            end
            default: ;
        endcase
    end

    assign C_DOUT    = C_RVALID ? MEM_DOUT2 : '0;
    assign CPU_STALL = (C_REQ & ~C_GNT) | ((state == RD_WAIT) & ~C_RVALID);

    // Counts programmer wins while the CPU is kept waiting; any CPU grant or
    // idle CPU cycle resets the fairness window.
    arb_starve_ctr #(.W(8), .MAX(STARVE_MAX)) u_starve (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .inc     (P_GNT & C_REQ & ~starve_full),
        .clr     (C_GNT | ~C_REQ),
        .cnt     (starve),
        .at_max  (starve_full)
    );

`ifdef MEM2_ARB_PERF_EN
    logic conf_full, stall_full;

    arb_starve_ctr #(.W(16), .MAX(16'hFFFF)) u_conf_cnt (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .inc     (C_REQ & P_REQ & ~conf_full),
        .clr     (1'b0),
        .cnt     (CONFLICT_CNT),
        .at_max  (conf_full)
    );

    arb_starve_ctr #(.W(16), .MAX(16'hFFFF)) u_stall_cnt (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .inc     (CPU_STALL & ~stall_full),
        .clr     (1'b0),
        .cnt     (STALL_CNT),
        .at_max  (stall_full)
    );
`endif

endmodule

// File: tb/tb_mem2_port_arbiter.sv
module tb_mem2_port_arbiter;
    import otter_mem_pkg::*;

    typedef struct {
        logic        c_req;
        logic        c_we;
        logic [31:0] c_addr;
        logic [31:0] c_din;
        logic [1:0]  c_size;
        logic        c_sign;
        logic        p_req;
        logic [31:0] p_addr;
        logic [31:0] p_din;
        logic [31:0] mdout;
    } in_t;

    typedef struct {
        logic        cgnt;
        logic        pgnt;
        logic        rv;
        logic [31:0] cdout;
        logic        stall;
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] din;
        logic [1:0]  size;
        logic        sign;
    } exp_t;

    typedef struct {
        in_t  i;
        exp_t e;
    } vec_t;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic rst_a, rst_b;
    in_t  ia, ib;
    int   checks = 0;
    int   failures = 0;

    logic        a_cgnt, a_pgnt, a_rv, a_stall, a_wr, a_rd, a_sign;
    logic [31:0] a_cdout, a_addr, a_din;
    logic [1:0]  a_size;
    logic        b_cgnt, b_pgnt, b_rv, b_stall, b_wr, b_rd, b_sign;
    logic [31:0] b_cdout, b_addr, b_din;
    logic [1:0]  b_size;
`ifdef MEM2_ARB_PERF_EN
    logic [15:0] a_conf, a_stc, b_conf, b_stc;
`endif

    // DUT A: RD_LAT=1, STARVE_MAX=8
    mem2_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1), .STARVE_MAX(8)) u_a (
        .CLK(CLK), .RESET_N(rst_a),
        .C_REQ(ia.c_req), .C_WE(ia.c_we), .C_ADDR(ia.c_addr), .C_DIN(ia.c_din),
        .C_SIZE(ia.c_size), .C_SIGN(ia.c_sign),
        .C_GNT(a_cgnt), .C_RVALID(a_rv), .C_DOUT(a_cdout), .CPU_STALL(a_stall),
        .P_REQ(ia.p_req), .P_ADDR(ia.p_addr), .P_DIN(ia.p_din), .P_GNT(a_pgnt),
        .MEM_ADDR2(a_addr), .MEM_DIN2(a_din), .MEM_WRITE2(a_wr), .MEM_READ2(a_rd),
        .MEM_SIZE(a_size), .MEM_SIGN(a_sign), .MEM_DOUT2(ia.mdout)
`ifdef MEM2_ARB_PERF_EN
        , .CONFLICT_CNT(a_conf), .STALL_CNT(a_stc)
`endif
    );

    // DUT B: RD_LAT=3, STARVE_MAX=2
    mem2_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(3), .STARVE_MAX(2)) u_b (
        .CLK(CLK), .RESET_N(rst_b),
        .C_REQ(ib.c_req), .C_WE(ib.c_we), .C_ADDR(ib.c_addr), .C_DIN(ib.c_din),
        .C_SIZE(ib.c_size), .C_SIGN(ib.c_sign),
        .C_GNT(b_cgnt), .C_RVALID(b_rv), .C_DOUT(b_cdout), .CPU_STALL(b_stall),
        .P_REQ(ib.p_req), .P_ADDR(ib.p_addr), .P_DIN(ib.p_din), .P_GNT(b_pgnt),
        .MEM_ADDR2(b_addr), .MEM_DIN2(b_din), .MEM_WRITE2(b_wr), .MEM_READ2(b_rd),
        .MEM_SIZE(b_size), .MEM_SIGN(b_sign), .MEM_DOUT2(ib.mdout)
`ifdef MEM2_ARB_PERF_EN
        , .CONFLICT_CNT(b_conf), .STALL_CNT(b_stc)
`endif
    );

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    vec_t tbl[11];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // {c_req,c_we,c_addr,c_din,c_size,c_sign,p_req,p_addr,p_din,mdout} ->
        // {cgnt,pgnt,rv,cdout,stall,wr,rd,addr,din,size,sign}
        tbl[0]  = '{'{1'b0,1'b0,32'h0,32'h0,SZ_BYTE,1'b0,1'b0,32'h0,32'h0,32'h0},
                    '{1'b0,1'b0,1'b0,32'h0,1'b0,1'b0,1'b0,32'h0,32'h0,SZ_BYTE,1'b0}};
        tbl[1]  = '{'{1'b1,1'b0,32'h100,32'h0,SZ_WORD,1'b0,1'b0,32'h0,32'h0,32'hDEADBEEF},
                    '{1'b1,1'b0,1'b0,32'h0,1'b0,1'b0,1'b1,32'h100,32'h0,SZ_WORD,1'b0}};
        tbl[2]  = '{'{1'b0,1'b0,32'h0,32'h0,SZ_BYTE,1'b0,1'b0,32'h0,32'h0,32'hDEADBEEF},
                    '{1'b0,1'b0,1'b1,32'hDEADBEEF,1'b0,1'b0,1'b0,32'h0,32'h0,SZ_BYTE,1'b0}};
        tbl[3]  = '{'{1'b1,1'b1,32'h11,32'hAB,SZ_BYTE,1'b1,1'b0,32'h0,32'h0,32'h0},
                    '{1'b1,1'b0,1'b0,32'h0,1'b0,1'b1,1'b0,32'h11,32'hAB,SZ_BYTE,1'b1}};
        tbl[4]  = '{'{1'b1,1'b1,32'h22,32'h1234,SZ_HALF,1'b0,1'b1,32'h200,32'hCAFE0001,32'h0},
                    '{1'b0,1'b1,1'b0,32'h0,1'b1,1'b1,1'b0,32'h200,32'hCAFE0001,SZ_WORD,1'b0}};
        tbl[5]  = '{'{1'b1,1'b1,32'h22,32'h1234,SZ_HALF,1'b0,1'b0,32'h0,32'h0,32'h0},
                    '{1'b1,1'b0,1'b0,32'h0,1'b0,1'b1,1'b0,32'h22,32'h1234,SZ_HALF,1'b0}};
        tbl[6]  = '{'{1'b1,1'b0,32'h30,32'h0,SZ_HALF,1'b1,1'b0,32'h0,32'h0,32'h0},
                    '{1'b1,1'b0,1'b0,32'h0,1'b0,1'b0,1'b1,32'h30,32'h0,SZ_HALF,1'b1}};
        tbl[7]  = '{'{1'b1,1'b1,32'h40,32'h77,SZ_WORD,1'b0,1'b0,32'h0,32'h0,32'hBEEF},
                    '{1'b0,1'b0,1'b1,32'hBEEF,1'b1,1'b0,1'b0,32'h0,32'h0,SZ_BYTE,1'b0}};
        tbl[8]  = '{'{1'b1,1'b1,32'h40,32'h77,SZ_WORD,1'b0,1'b0,32'h0,32'h0,32'hBEEF},
                    '{1'b1,1'b0,1'b0,32'h0,1'b0,1'b1,1'b0,32'h40,32'h77,SZ_WORD,1'b0}};
        tbl[9]  = '{'{1'b0,1'b0,32'h0,32'h0,SZ_BYTE,1'b0,1'b1,32'h300,32'h5,32'h0},
                    '{1'b0,1'b1,1'b0,32'h0,1'b0,1'b1,1'b0,32'h300,32'h5,SZ_WORD,1'b0}};
        tbl[10] = tbl[0];

        rst_a = 1'b0;
        rst_b = 1'b0;
        ia = '{default: '0};
        ib = '{default: '0};

        // Reset state
        #2;
        chk1("rst_a_cgnt", a_cgnt, 1'b0);
        chk1("rst_a_pgnt", a_pgnt, 1'b0);
        chk1("rst_a_rv",   a_rv,   1'b0);
        chk1("rst_a_wr",   a_wr,   1'b0);
        chk1("rst_a_rd",   a_rd,   1'b0);
        chk1("rst_b_stall", b_stall, 1'b0);
        @(negedge CLK);
        @(negedge CLK);
        rst_a = 1'b1;
        rst_b = 1'b1;

        // Table-driven sequence on DUT A
        for (int k = 0; k < 11; k++) begin
            @(negedge CLK);
            ia = tbl[k].i;
            #2;
            chk1($sformatf("v%0d_cgnt", k), a_cgnt, tbl[k].e.cgnt);
            chk1($sformatf("v%0d_pgnt", k), a_pgnt, tbl[k].e.pgnt);
            chk1($sformatf("v%0d_rvalid", k), a_rv, tbl[k].e.rv);
            chk ($sformatf("v%0d_cdout", k), a_cdout, tbl[k].e.cdout);
            chk1($sformatf("v%0d_stall", k), a_stall, tbl[k].e.stall);
            chk1($sformatf("v%0d_wr", k), a_wr, tbl[k].e.wr);
            chk1($sformatf("v%0d_rd", k), a_rd, tbl[k].e.rd);
            chk ($sformatf("v%0d_addr", k), a_addr, tbl[k].e.addr);
            chk ($sformatf("v%0d_din", k), a_din, tbl[k].e.din);
            chk ($sformatf("v%0d_size", k), 32'(a_size), 32'(tbl[k].e.size));
            chk1($sformatf("v%0d_sign", k), a_sign, tbl[k].e.sign);
        end

        // DUT B: RD_LAT=3 read, then back-to-back write
        @(negedge CLK);
        ib.c_req = 1'b1; ib.c_we = 1'b0; ib.c_addr = 32'h80; ib.c_size = SZ_WORD;
        #2;
        chk1("b2b_rd_gnt", b_cgnt, 1'b1);
        chk1("b2b_rd_strobe", b_rd, 1'b1);
        chk1("b2b_rd_stall0", b_stall, 1'b0);
        @(negedge CLK);
        ib.c_we = 1'b1; ib.c_addr = 32'h84; ib.c_din = 32'hA5A5;
        #2;
        chk1("b2b_p1_gnt", b_cgnt, 1'b0);
        chk1("b2b_p1_stall", b_stall, 1'b1);
        chk1("b2b_p1_rv", b_rv, 1'b0);
        @(negedge CLK);
        #2;
        chk1("b2b_p2_stall", b_stall, 1'b1);
        chk1("b2b_p2_rv", b_rv, 1'b0);
        @(negedge CLK);
        ib.mdout = 32'h1111;
        #2;
        chk1("b2b_p3_rv", b_rv, 1'b1);
        chk ("b2b_p3_dout", b_cdout, 32'h1111);
        chk1("b2b_p3_gnt", b_cgnt, 1'b0);
        chk1("b2b_p3_stall", b_stall, 1'b1);
        @(negedge CLK);
        #2;
        chk1("b2b_p4_gnt", b_cgnt, 1'b1);
        chk1("b2b_p4_wr", b_wr, 1'b1);
        chk ("b2b_p4_addr", b_addr, 32'h84);
        chk1("b2b_p4_stall", b_stall, 1'b0);
        @(negedge CLK);
        ib = '{default: '0};

        // DUT B: starvation limit 2 -> P,P,C,P,P,C
        @(negedge CLK);
        ib.c_req = 1'b1; ib.c_we = 1'b1; ib.c_addr = 32'h10;
        ib.p_req = 1'b1; ib.p_addr = 32'h20;
        for (int k = 0; k < 6; k++) begin
            #2;
            chk1($sformatf("starve%0d_pgnt", k), b_pgnt, (k % 3) != 2);
            chk1($sformatf("starve%0d_cgnt", k), b_cgnt, (k % 3) == 2);
            @(negedge CLK);
        end
        ib = '{default: '0};

        // DUT B: reset during RD_WAIT
        @(negedge CLK);
        ib.c_req = 1'b1; ib.c_we = 1'b0; ib.c_addr = 32'h90; ib.c_size = SZ_WORD;
        #2;
        chk1("rstrd_gnt", b_cgnt, 1'b1);
        @(negedge CLK);
        ib.c_req = 1'b0;
        ib.p_req = 1'b1; ib.p_addr = 32'h44; ib.p_din = 32'h99;
        #2;
        chk1("rdwait_no_pgnt", b_pgnt, 1'b0);
        #1;
        rst_b = 1'b0;
        #1;
        chk1("rstrd_pgnt", b_pgnt, 1'b0);
        chk1("rstrd_cgnt", b_cgnt, 1'b0);
        chk1("rstrd_wr", b_wr, 1'b0);
        chk1("rstrd_rd", b_rd, 1'b0);
        chk1("rstrd_rv", b_rv, 1'b0);
        @(negedge CLK);
        #2;
        chk1("rsthold_pgnt", b_pgnt, 1'b0);
        chk1("rsthold_wr", b_wr, 1'b0);
        @(negedge CLK);
        rst_b = 1'b1;
        #2;
        chk1("rstrel_pgnt", b_pgnt, 1'b1);
        chk ("rstrel_addr", b_addr, 32'h44);
        @(negedge CLK);
        ib = '{default: '0};
        for (int k = 0; k < 4; k++) begin
            #2;
            chk1($sformatf("rstrel_no_rv%0d", k), b_rv, 1'b0);
            @(negedge CLK);
        end

`ifdef MEM2_ARB_PERF_EN
        // Perf counters on DUT A from a fresh reset
        rst_a = 1'b0;
        @(negedge CLK);
        rst_a = 1'b1;
        ia = '{default: '0};
        ia.c_req = 1'b1; ia.c_we = 1'b1; ia.p_req = 1'b1; ia.p_addr = 32'h8;
        for (int k = 0; k < 5; k++) @(negedge CLK);
        ia = '{default: '0};
        #2;
        chk("perf_conflict5", 32'(a_conf), 32'd5);
        chk("perf_stall5", 32'(a_stc), 32'd5);
        begin
            int stall_seen;
            int cyc;
            stall_seen = 0;
            cyc = 0;
            @(negedge CLK);
            ia.c_req = 1'b1; ia.c_we = 1'b1; ia.p_req = 1'b1;
            while (stall_seen < 66000 && cyc < 80000) begin
                #2;
                if (a_stall) stall_seen++;
                cyc++;
                @(negedge CLK);
            end
            ia = '{default: '0};
            #2;
            chk("perf_stall_budget", 32'(stall_seen), 32'd66000);
            chk("perf_stall_sat", 32'(a_stc), 32'h0000FFFF);
            chk("perf_conflict_sat", 32'(a_conf), 32'h0000FFFF);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
